// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: default frame geometry and the receiver FSM encoding.
package uart_rx_pkg;

    localparam int unsigned DefaultWordSize   = 8;
    localparam int unsigned DefaultNumSamples = 8;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StStarting  = 2'd1,
        StReceiving = 2'd2
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Line input and host-side valid/ack handshake of the UART receiver.
interface uart_rx_if #(
    parameter int unsigned WordSize = 8
);

    logic                serial_in;
    logic                rx_ack;
    logic [WordSize-1:0] rx_data;
    logic                rx_valid;
    logic                framing_err;
    logic                overrun_err;

    modport master (
        output serial_in,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  framing_err,
        input  overrun_err
    );

    modport slave (
        input  serial_in,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output framing_err,
        output overrun_err
    );

endinterface

// File: rtl/uart_rx_control.sv
// Receiver sequencing: start-bit centring, bit timing and shift/load strobes.
module uart_rx_control
    import uart_rx_pkg::*;
#(
    parameter int unsigned WordSize   = DefaultWordSize,
    parameter int unsigned NumSamples = DefaultNumSamples
) (
    input  logic clk,
    input  logic rst_b,
    input  logic s_sync_i,
    output logic shift_o,
    output logic load_o
);

    localparam int unsigned SampleW = $clog2(NumSamples);
    localparam int unsigned BitW    = $clog2(WordSize + 1);

    localparam logic [SampleW-1:0] HalfMax = SampleW'(NumSamples / 2 - 1);
    localparam logic [SampleW-1:0] FullMax = SampleW'(NumSamples - 1);
    localparam logic [BitW-1:0]    StopIdx = BitW'(WordSize);

    rx_state_e          state_q, state_d;
    logic [SampleW-1:0] sample_cnt_q, sample_cnt_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_o      = 1'b0;
        load_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                sample_cnt_d = '0;
                bit_cnt_d    = '0;
                if (!s_sync_i) state_d = StStarting;
            end
            StStarting: begin
                // A start bit that does not survive to its centre is line noise.
                if (s_sync_i) begin
                    state_d      = StIdle;
                    sample_cnt_d = '0;
                end else if (sample_cnt_q == HalfMax) begin
                    state_d      = StReceiving;
                    sample_cnt_d = '0;
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            StReceiving: begin
                if (sample_cnt_q == FullMax) begin
                    sample_cnt_d = '0;
                    if (bit_cnt_q == StopIdx) begin
                        load_o    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        shift_o   = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: input synchronizer, data shifter, output registers and host handshake.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned WordSize   = DefaultWordSize,
    parameter int unsigned NumSamples = DefaultNumSamples
) (
    input  logic     clk,
    input  logic     rst_b,
    uart_rx_if.slave bus
);

    logic [1:0]          sync_q;
    logic                s_sync;
    logic                shift;
    logic                load;
    logic [WordSize-1:0] shift_q, shift_d;
    logic [WordSize-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                oerr_q, oerr_d;

    // Two-flop synchronizer, reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.serial_in};
        end
    end

    assign s_sync = sync_q[1];

    uart_rx_control #(
        .WordSize   (WordSize),
        .NumSamples (NumSamples)
    ) u_control (
        .clk      (clk),
        .rst_b    (rst_b),
        .s_sync_i (s_sync),
        .shift_o  (shift),
        .load_o   (load)
    );

    always_comb begin
        shift_d = shift_q;
        if (shift) shift_d = {s_sync, shift_q[WordSize-1:1]};
    end

    // A load wins over a same-cycle ack; the ack then only suppresses the overrun flag.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        oerr_d  = oerr_q;
        if (load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = ~s_sync;
            oerr_d  = valid_q & ~bus.rx_ack;
        end else if (bus.rx_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.framing_err = ferr_q;
    assign bus.overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame-level bench for uart_rx against a word-level reference of the receive rules.
module tb_uart_rx;

    localparam int W        = 8;
    localparam int N        = 8;
    localparam int FrameCyc = (W + 2) * N;
    // Stop-bit sample / output update edge, counted from the first edge that sees the start bit.
    localparam int LoadCyc  = N / 2 + 2 + (W + 1) * N;

    logic clk;
    logic rst_b;

    uart_rx_if #(.WordSize(W)) bus ();

    uart_rx #(
        .WordSize   (W),
        .NumSamples (N)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_ferr;
    logic         exp_oerr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".data"}, 32'(bus.rx_data), 32'(exp_data));
        check_eq({tag, ".valid"}, 32'(bus.rx_valid), 32'(exp_valid));
        check_eq({tag, ".ferr"}, 32'(bus.framing_err), 32'(exp_ferr));
        check_eq({tag, ".oerr"}, 32'(bus.overrun_err), 32'(exp_oerr));
    endtask

    task automatic model_reset();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_oerr  = 1'b0;
    endtask

    // Idle line for n cycles; optionally pulse rx_ack at cycle ack_at and check it took effect.
    task automatic idle(input int n, input bit do_ack, input int ack_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.serial_in = 1'b1;
            bus.rx_ack    = do_ack && (i == ack_at);
            if (do_ack && i == ack_at + 1) begin
                exp_valid = 1'b0;
                check_eq("ack.valid", 32'(bus.rx_valid), 32'(exp_valid));
            end
        end
        bus.rx_ack = 1'b0;
    endtask

    // One frame, one line cycle per negedge. Cycle c feeds the posedge F+c. Cycles past the
    // driven stop bit carry the next start bit when tail_low is set.
    task automatic send_frame(input logic [W-1:0] word, input bit stop, input int stop_cycles,
                              input bit tail_low, input int first_cyc, input bit ack_on_load,
                              input int abort_cyc);
        for (int cyc = first_cyc; cyc < FrameCyc; cyc++) begin
            @(negedge clk);
            if (cyc == abort_cyc) begin
                rst_b = 1'b0;
                #1;
                model_reset();
                check_outputs("abort");
                return;
            end
            if (cyc < N) bus.serial_in = 1'b0;
            else if (cyc < (W + 1) * N) bus.serial_in = word[cyc/N-1];
            else if (cyc < (W + 1) * N + stop_cycles) bus.serial_in = stop;
            else bus.serial_in = !tail_low;
            if (cyc == LoadCyc) begin
                check_eq("pre.valid", 32'(bus.rx_valid), 32'(exp_valid));
                check_eq("pre.data", 32'(bus.rx_data), 32'(exp_data));
                bus.rx_ack = ack_on_load;
            end
            if (cyc == LoadCyc + 1) begin
                bus.rx_ack = 1'b0;
                exp_oerr   = exp_valid & ~ack_on_load;
                exp_valid  = 1'b1;
                exp_data   = word;
                exp_ferr   = ~stop;
                check_outputs("load");
            end
        end
    endtask

    initial begin
        logic [W-1:0] w;
        bit           stop;
        int           mode;

        rst_b         = 1'b0;
        bus.serial_in = 1'b1;
        bus.rx_ack    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_b = 1'b1;
        idle(10, 1'b0, 0);

        send_frame(8'hA5, 1'b1, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b1, 4);

        send_frame(8'h3C, 1'b0, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b0, 0);
        send_frame(8'h01, 1'b1, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b1, 4);

        send_frame(8'h11, 1'b1, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b0, 0);
        send_frame(8'h22, 1'b1, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b1, 3);
        send_frame(8'h11, 1'b1, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b0, 0);
        send_frame(8'h22, 1'b1, 8, 1'b0, 0, 1'b1, -1);
        idle(16, 1'b1, 3);

        // Short low pulse must leave outputs untouched, even long after a frame would finish.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.serial_in = 1'b0;
        end
        idle(120, 1'b0, 0);
        check_outputs("glitch");
        send_frame(8'hFF, 1'b1, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b1, 3);

        // Next start bit begins in the second half of the stop bit.
        send_frame(8'h00, 1'b1, 5, 1'b1, 0, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 8, 1'b0, 3, 1'b0, -1);
        idle(16, 1'b0, 0);

        // Reset in the middle of data bit 4 with an unconsumed word pending.
        send_frame(8'h96, 1'b1, 8, 1'b0, 0, 1'b0, 4 * N + N + 3);
        bus.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("in_reset");
        rst_b = 1'b1;
        idle(16, 1'b0, 0);
        send_frame(8'h5A, 1'b1, 8, 1'b0, 0, 1'b0, -1);
        idle(16, 1'b1, 3);

        for (int k = 0; k < 20; k++) begin
            w    = W'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            mode = int'($urandom_range(0, 2));
            send_frame(w, stop, 8, 1'b0, 0, mode == 1, -1);
            idle(12 + int'($urandom_range(0, 8)), mode == 2, 3);
        end
        check_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
